// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the alu_regfile datapath: fetches one- or two-beat
// instructions, drives a single EXEC cycle, then commits via WB or redirects the pc.
module alu_seq_ctrl #(
  parameter logic [7:0] PC_RESET    = 8'h00,
  parameter bit         HALT_ON_OVF = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  input  logic [7:0] alu_result,
  input  logic       alu_ovf,
  input  logic       alu_take_branch,
  output logic       RegWrite,
  output logic [1:0] ReadAddr1,
  output logic [1:0] ReadAddr2,
  output logic [1:0] WriteAddr,
  output logic [8:0] WriteData,
  output logic [7:0] Instr_i,
  output logic       ALUSrc1,
  output logic       ALUSrc2,
  output logic [2:0] ALUOp,
  output logic [7:0] pc,
  output logic       redirect,
  output logic       ovf_sticky,
  output logic       halted
);

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 2;
  localparam int unsigned OPW = 3;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_IMM   = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Decoded instruction latch
  logic [OPW-1:0] r_op,  w_op_nxt;
  logic [AW-1:0]  r_rd,  w_rd_nxt;
  logic [AW-1:0]  r_rs2, w_rs2_nxt;
  logic           r_imm, w_imm_nxt;
  logic [DW-1:0]  r_ipc, w_ipc_nxt;

  logic           r_ready,    w_ready_nxt;
  logic           r_regwrite, w_regwrite_nxt;
  logic [AW-1:0]  r_ra1,      w_ra1_nxt;
  logic [AW-1:0]  r_ra2,      w_ra2_nxt;
  logic [AW-1:0]  r_wa,       w_wa_nxt;
  logic [DW:0]    r_wd,       w_wd_nxt;
  logic [DW-1:0]  r_instr_i,  w_instr_i_nxt;
  logic           r_src1,     w_src1_nxt;
  logic           r_src2,     w_src2_nxt;
  logic [OPW-1:0] r_aluop,    w_aluop_nxt;
  logic [DW-1:0]  r_pc,       w_pc_nxt;
  logic           r_redirect, w_redirect_nxt;
  logic           r_sticky,   w_sticky_nxt;
  logic           r_halted,   w_halted_nxt;

  logic w_xfer;
  logic w_halt;
  logic w_branch;

  assign w_xfer   = instr_valid & r_ready;
  assign w_halt   = HALT_ON_OVF & alu_ovf;
  assign w_branch = alu_take_branch & r_imm;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; overflow halt outranks branch, branch outranks writeback
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (w_xfer) w_state_nxt = instr_data[0] ? S_IMM : S_EXEC;
      S_IMM:   if (w_xfer) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_halt)        w_state_nxt = S_HALT;
        else if (w_branch) w_state_nxt = S_FETCH;
        else               w_state_nxt = S_WB;
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Next values of the registered outputs and the instruction latch
  always_comb begin
    w_op_nxt       = r_op;
    w_rd_nxt       = r_rd;
    w_rs2_nxt      = r_rs2;
    w_imm_nxt      = r_imm;
    w_ipc_nxt      = r_ipc;
    w_regwrite_nxt = 1'b0;
    w_redirect_nxt = 1'b0;
    w_ra1_nxt      = r_ra1;
    w_ra2_nxt      = r_ra2;
    w_wa_nxt       = r_wa;
    w_wd_nxt       = r_wd;
    w_instr_i_nxt  = r_instr_i;
    w_src1_nxt     = r_src1;
    w_src2_nxt     = r_src2;
    w_aluop_nxt    = r_aluop;
    w_pc_nxt       = r_pc;
    w_sticky_nxt   = r_sticky;
    w_ready_nxt    = (w_state_nxt == S_FETCH) || (w_state_nxt == S_IMM);
    w_halted_nxt   = (w_state_nxt == S_HALT);
    case (r_state)
      S_FETCH: begin
        if (w_xfer) begin
          w_pc_nxt  = r_pc + DW'(1);
          w_ipc_nxt = r_pc;
          w_op_nxt  = instr_data[7:5];
          w_rd_nxt  = instr_data[4:3];
          w_rs2_nxt = instr_data[2:1];
          w_imm_nxt = instr_data[0];
          // Register-only form goes straight to EXEC, so selects load now
          if (!instr_data[0]) begin
            w_ra1_nxt   = instr_data[4:3];
            w_ra2_nxt   = instr_data[2:1];
            w_aluop_nxt = instr_data[7:5];
            w_src1_nxt  = 1'b0;
            w_src2_nxt  = 1'b0;
          end
        end
      end
      S_IMM: begin
        if (w_xfer) begin
          w_pc_nxt      = r_pc + DW'(1);
          w_instr_i_nxt = instr_data;
          w_ra1_nxt     = r_rd;
          w_ra2_nxt     = r_rs2;
          w_aluop_nxt   = r_op;
          w_src1_nxt    = (r_rs2 == AW'(3));
          w_src2_nxt    = 1'b1;
        end
      end
      S_EXEC: begin
        w_wd_nxt     = {alu_ovf, alu_result};
        w_sticky_nxt = r_sticky | alu_ovf;
        if (!w_halt) begin
          if (w_branch) begin
            w_pc_nxt       = r_ipc + r_instr_i;
            w_redirect_nxt = 1'b1;
          end else begin
            w_regwrite_nxt = 1'b1;
            w_wa_nxt       = r_rd;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_rd       <= '0;
      r_rs2      <= '0;
      r_imm      <= 1'b0;
      r_ipc      <= '0;
      r_ready    <= 1'b1;
      r_regwrite <= 1'b0;
      r_ra1      <= '0;
      r_ra2      <= '0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_instr_i  <= '0;
      r_src1     <= 1'b0;
      r_src2     <= 1'b0;
      r_aluop    <= '0;
      r_pc       <= PC_RESET;
      r_redirect <= 1'b0;
      r_sticky   <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_op       <= w_op_nxt;
      r_rd       <= w_rd_nxt;
      r_rs2      <= w_rs2_nxt;
      r_imm      <= w_imm_nxt;
      r_ipc      <= w_ipc_nxt;
      r_ready    <= w_ready_nxt;
      r_regwrite <= w_regwrite_nxt;
      r_ra1      <= w_ra1_nxt;
      r_ra2      <= w_ra2_nxt;
      r_wa       <= w_wa_nxt;
      r_wd       <= w_wd_nxt;
      r_instr_i  <= w_instr_i_nxt;
      r_src1     <= w_src1_nxt;
      r_src2     <= w_src2_nxt;
      r_aluop    <= w_aluop_nxt;
      r_pc       <= w_pc_nxt;
      r_redirect <= w_redirect_nxt;
      r_sticky   <= w_sticky_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  assign instr_ready = r_ready;
  assign RegWrite    = r_regwrite;
  assign ReadAddr1   = r_ra1;
  assign ReadAddr2   = r_ra2;
  assign WriteAddr   = r_wa;
  assign WriteData   = r_wd;
  assign Instr_i     = r_instr_i;
  assign ALUSrc1     = r_src1;
  assign ALUSrc2     = r_src2;
  assign ALUOp       = r_aluop;
  assign pc          = r_pc;
  assign redirect    = r_redirect;
  assign ovf_sticky  = r_sticky;
  assign halted      = r_halted;

endmodule
